// File: rtl/order_queue.sv
// order_queue: FWFT recirculation queue for non-final ALU beats, with a registered result port for final beats.
module order_queue #(
  parameter int WID_D   = 32,
  parameter int CNT_W   = 5,
  parameter int ORD_NUM = 30,
  parameter int DEPTH   = 8,
  parameter int AW      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WID_D-1:0] alu_a_left,
  input  logic [WID_D-1:0] alu_a_right,
  input  logic [CNT_W-1:0] alu_order_cnt,
  input  logic             alu_dt_vld,
  output logic             alu_rdy,
  output logic [WID_D-1:0] que_a_left,
  output logic [WID_D-1:0] que_a_right,
  output logic [CNT_W-1:0] que_order_cnt,
  output logic             que_dt_vld,
  input  logic             mux2que_rdy,
  output logic [WID_D-1:0] res_a_left,
  output logic [WID_D-1:0] res_a_right,
  output logic             res_vld,
  output logic [AW:0]      que_cnt,
  output logic             ovf_err
);
  logic [2*WID_D+CNT_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic final_beat, push, pop, drop;
  always_comb begin
    final_beat = alu_order_cnt >= CNT_W'(ORD_NUM - 1);
    push = alu_dt_vld && !final_beat && alu_rdy;
    drop = alu_dt_vld && !final_beat && !alu_rdy;
    pop = que_dt_vld && mux2que_rdy;
  end
  assign alu_rdy = count < (AW+1)'(DEPTH);
  assign que_dt_vld = count != '0;
  assign que_cnt = count;
  assign {que_a_left, que_a_right, que_order_cnt} = mem[rptr];
  // storage carries no reset so it maps onto plain RAM
  always_ff @(posedge clk)
    if (push && !rst) mem[wptr] <= {alu_a_left, alu_a_right, alu_order_cnt + CNT_W'(1)};
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      ovf_err <= 1'b0;
      res_vld <= 1'b0;
      res_a_left <= '0;
      res_a_right <= '0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      ovf_err <= ovf_err || drop;
      res_vld <= alu_dt_vld && final_beat;
      if (alu_dt_vld && final_beat) begin
        res_a_left <= alu_a_left;
        res_a_right <= alu_a_right;
      end
    end
  end
endmodule

// File: tb/tb_order_queue.sv
// tb_order_queue: scoreboard-driven checks of queue order, overflow, final bypass and reset.
module tb_order_queue;
  logic clk = 0, rst = 0;
  logic [31:0] alu_a_left = 0, alu_a_right = 0;
  logic [4:0] alu_order_cnt = 0;
  logic alu_dt_vld = 0, mux2que_rdy = 0;
  logic alu_rdy, que_dt_vld, res_vld, ovf_err;
  logic [31:0] que_a_left, que_a_right, res_a_left, res_a_right;
  logic [4:0] que_order_cnt;
  logic [3:0] que_cnt;

  typedef struct packed {logic [31:0] l, r; logic [4:0] c;} ent_t;
  ent_t sb[$];
  int mcount = 0, total = 0, bad = 0;
  logic movf = 0, mres_vld = 0;
  logic [31:0] mres_l = 0, mres_r = 0;

  order_queue dut (
    .clk(clk), .rst(rst),
    .alu_a_left(alu_a_left), .alu_a_right(alu_a_right),
    .alu_order_cnt(alu_order_cnt), .alu_dt_vld(alu_dt_vld), .alu_rdy(alu_rdy),
    .que_a_left(que_a_left), .que_a_right(que_a_right),
    .que_order_cnt(que_order_cnt), .que_dt_vld(que_dt_vld),
    .mux2que_rdy(mux2que_rdy),
    .res_a_left(res_a_left), .res_a_right(res_a_right), .res_vld(res_vld),
    .que_cnt(que_cnt), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic step(input bit v, input logic [31:0] l, input logic [31:0] r,
                      input logic [4:0] c, input bit rd);
    bit fin, push_ok, pop_ok;
    alu_dt_vld = v; alu_a_left = l; alu_a_right = r; alu_order_cnt = c; mux2que_rdy = rd;
    fin = v && c >= 5'd29;
    push_ok = v && !fin && mcount < 8;
    pop_ok = rd && mcount > 0;
    @(posedge clk); #1;
    alu_dt_vld = 0; mux2que_rdy = 0;
    if (rst) begin
      sb.delete(); mcount = 0; movf = 0; mres_vld = 0; mres_l = 0; mres_r = 0;
    end else begin
      if (pop_ok) void'(sb.pop_front());
      if (push_ok) sb.push_back('{l, r, c + 5'd1});
      mcount = mcount + int'(push_ok) - int'(pop_ok);
      if (v && !fin && mcount == 8 && !push_ok) movf = 1;
      mres_vld = fin;
      if (fin) begin mres_l = l; mres_r = r; end
    end
  endtask

  task automatic test_reset;
    rst = 1; step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0); rst = 0;
    total++; if (que_dt_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", que_dt_vld); end
    total++; if (que_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", que_cnt); end
    total++; if (alu_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", alu_rdy); end
    total++; if (res_vld !== 1'b0 || res_a_left !== 32'd0) begin bad++; $display("FAIL reset_res got=%b/%h want=0/0", res_vld, res_a_left); end
    total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf_err); end
  endtask

  task automatic test_single;
    step(1, 32'h11, 32'h22, 5'd3, 0);
    total++; if (que_dt_vld !== 1'b1) begin bad++; $display("FAIL single_vld got=%b want=1", que_dt_vld); end
    total++; if ({que_a_left, que_a_right, que_order_cnt} !== {32'h11, 32'h22, 5'd4})
      begin bad++; $display("FAIL single_head got=%h/%h/%0d want=11/22/4", que_a_left, que_a_right, que_order_cnt); end
    total++; if ({que_a_left, que_a_right, que_order_cnt} !== sb[0])
      begin bad++; $display("FAIL single_sb got=%h want=%h", {que_a_left, que_a_right, que_order_cnt}, sb[0]); end
    step(0, 0, 0, 0, 1);
    total++; if (que_dt_vld !== 1'b0 || que_cnt !== 4'd0)
      begin bad++; $display("FAIL single_pop got=%b/%0d want=0/0", que_dt_vld, que_cnt); end
  endtask

  task automatic test_fill_wrap;
    for (int i = 0; i < 8; i++) step(1, i, 32'(i + 100), 5'(i % 7), 0);
    total++; if (que_cnt !== 4'd8 || alu_rdy !== 1'b0)
      begin bad++; $display("FAIL full got cnt=%0d rdy=%b want=8/0", que_cnt, alu_rdy); end
    step(1, 32'd99, 32'd99, 5'd2, 0);
    total++; if (ovf_err !== 1'b1 || que_cnt !== 4'd8)
      begin bad++; $display("FAIL drop got ovf=%b cnt=%0d want=1/8", ovf_err, que_cnt); end
    step(1, 32'hABCD, 32'h1234, 5'd29, 0);
    total++; if (res_vld !== 1'b1 || res_a_left !== 32'hABCD || res_a_right !== 32'h1234)
      begin bad++; $display("FAIL final got %b/%h/%h want 1/abcd/1234", res_vld, res_a_left, res_a_right); end
    total++; if (que_cnt !== 4'd8 || ovf_err !== 1'b1)
      begin bad++; $display("FAIL final_que got cnt=%0d ovf=%b want=8/1", que_cnt, ovf_err); end
    step(0, 0, 0, 0, 0);
    total++; if (res_vld !== 1'b0) begin bad++; $display("FAIL final_pulse got=%b want=0", res_vld); end
    for (int i = 0; i < 8; i++) begin
      total++; if (que_a_left !== 32'(i) || {que_a_left, que_a_right, que_order_cnt} !== sb[0])
        begin bad++; $display("FAIL drain%0d got=%h want=%h", i, {que_a_left, que_a_right, que_order_cnt}, sb[0]); end
      step(0, 0, 0, 0, 1);
    end
    for (int i = 0; i < 3; i++) step(1, 32'(50 + i), 32'(60 + i), 5'd10, 0);
    for (int i = 0; i < 3; i++) begin
      total++; if (que_a_left !== 32'(50 + i) || {que_a_left, que_a_right, que_order_cnt} !== sb[0])
        begin bad++; $display("FAIL wrap%0d got=%h want=%h", i, {que_a_left, que_a_right, que_order_cnt}, sb[0]); end
      step(0, 0, 0, 0, 1);
    end
    total++; if (que_cnt !== 4'd0) begin bad++; $display("FAIL wrap_empty got=%0d want=0", que_cnt); end
  endtask

  task automatic test_back_to_back;
    step(1, 32'h100, 32'h200, 5'd3, 0);
    step(1, 32'h300, 32'h400, 5'd4, 0);
    step(1, 32'h500, 32'h600, 5'd5, 0);
    for (int i = 0; i < 10; i++) begin
      total++; if ({que_a_left, que_a_right, que_order_cnt} !== sb[0])
        begin bad++; $display("FAIL simul_head%0d got=%h want=%h", i, {que_a_left, que_a_right, que_order_cnt}, sb[0]); end
      step(1, $urandom, $urandom, 5'($urandom_range(0, 28)), 1);
      total++; if (que_cnt !== 4'd3) begin bad++; $display("FAIL simul_cnt%0d got=%0d want=3", i, que_cnt); end
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 32'(700 + i), 32'(800 + i), 5'd29, 0);
      total++; if (res_vld !== mres_vld || res_a_left !== mres_l || res_a_right !== mres_r)
        begin bad++; $display("FAIL b2b_res%0d got=%b/%h/%h want=%b/%h/%h", i, res_vld, res_a_left, res_a_right, mres_vld, mres_l, mres_r); end
    end
  endtask

  task automatic test_reset_mid;
    step(1, 32'd1, 32'd2, 5'd1, 0);
    step(1, 32'd3, 32'd4, 5'd1, 0);
    total++; if (que_cnt !== 4'd5 || ovf_err !== 1'b1)
      begin bad++; $display("FAIL pre_rst got cnt=%0d ovf=%b want=5/1", que_cnt, ovf_err); end
    rst = 1; step(1, 32'd5, 32'd6, 5'd29, 1); rst = 0;
    total++; if (que_cnt !== 4'd0 || que_dt_vld !== 1'b0 || ovf_err !== 1'b0 || res_vld !== 1'b0)
      begin bad++; $display("FAIL mid_rst got cnt=%0d vld=%b ovf=%b res=%b want=0/0/0/0", que_cnt, que_dt_vld, ovf_err, res_vld); end
    step(0, 0, 0, 0, 0);
    total++; if (que_cnt !== 4'd0 || res_vld !== 1'b0)
      begin bad++; $display("FAIL post_rst got cnt=%0d res=%b want=0/0", que_cnt, res_vld); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill_wrap;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/order_queue.md
# order_queue

Recirculation queue between the ALU result path and the arbiter's queue port in the polynomial evaluation pipeline. Each ALU result beat that still has orders to go is stored with its order count advanced by one, then presented back to the arbiter through a valid/ready handshake; the arbiter's ready is its own `mux2que_rdy`. A beat that has completed its last order (`ORD_NUM-1`) is not queued and leaves on a registered result port instead. Storage is a first-word-fall-through circular buffer.

## Interface
- `WID_D`, 32, data width of `a_left` / `a_right`
- `CNT_W`, 5, order counter width; `ORD_NUM-1 < 2^CNT_W`
- `ORD_NUM`, 30, number of orders per evaluation
- `DEPTH`, 8, queue entries; power of two
- `AW`, 3, pointer width, `log2(DEPTH)`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `alu_a_left`  in  WID_D  ALU result, left operand for the next order
- `alu_a_right`  in  WID_D  ALU result, right operand
- `alu_order_cnt`  in  CNT_W  order just completed by the ALU
- `alu_dt_vld`  in  1  ALU result valid
- `alu_rdy`  out  1  queue has space: `count < DEPTH`
- `que_a_left`  out  WID_D  head entry, left operand
- `que_a_right`  out  WID_D  head entry, right operand
- `que_order_cnt`  out  CNT_W  head entry, order count
- `que_dt_vld`  out  1  queue not empty
- `mux2que_rdy`  in  1  arbiter accepts the head this cycle
- `res_a_left`, `res_a_right`  out  WID_D  final evaluation result
- `res_vld`  out  1  one-cycle pulse marking a final result
- `que_cnt`  out  AW+1  occupancy, 0..DEPTH
- `ovf_err`  out  1  sticky flag: a non-final beat was dropped

## Operation
- **Classification.** An ALU beat is *final* if `alu_order_cnt >= ORD_NUM-1`. Otherwise it is *recirculating*.
- **Push.** Occurs when `alu_dt_vld` is high, the beat is recirculating, and `count < DEPTH`.
  - The entry written is `{alu_a_left, alu_a_right, alu_order_cnt+1}` into `mem[wptr]`.
  - `wptr` then increments.
  - The `+1` is computed at CNT_W width. No overflow is possible, given the constraint on `ORD_NUM`.
- **Drop.** Occurs when `alu_dt_vld` is high, the beat is recirculating, and `count == DEPTH`.
  - Nothing is written and the pointers are unchanged.
  - `ovf_err` is set and stays set until `rst`.
- **Final beat.** The beat is captured into the `res_*` registers and `res_vld` is high on the next cycle. This happens regardless of queue fullness and never touches the queue.
- **Pop.** Occurs when `que_dt_vld && mux2que_rdy`. `rptr` increments.
- **Head outputs.** `que_*` are driven combinationally from `mem[rptr]`. Their values are don't-care while `que_dt_vld` is low.
- **Pointers.** Both are AW bits and wrap from `DEPTH-1` to 0.
- **Count.** Per cycle, `count <= count + push - pop`. `que_cnt = count`. `que_dt_vld = (count != 0)`.
- **Simultaneous push and pop.**
  - Allowed at any non-full occupancy; `count` is unchanged.
  - When full, `alu_rdy` is low (it uses the registered count), so a push in that cycle is a drop even if a pop also occurs.
- **Reset.** A synchronous `rst` at any point, including mid-traffic, takes effect at that edge:
  - `wptr`, `rptr` and `count` go to 0.
  - `res_vld` and `ovf_err` go to 0.
  - `res_a_left` and `res_a_right` go to 0.
  - Memory contents are not cleared.
  - Pushes and pops in the reset cycle are ignored.

## Timing
- Values after reset:
  - `que_dt_vld` = 0, `que_cnt` = 0, `alu_rdy` = 1
  - `res_vld` = 0, `res_a_*` = 0, `ovf_err` = 0
  - `que_*` data is undefined (memory contents)
- Push to visibility: 1 cycle. A push at edge N into an empty queue gives `que_dt_vld` = 1 after edge N. There is no same-cycle bypass.
- Pop: the arbiter samples `que_*` in the same cycle it sees `que_dt_vld` and drives `mux2que_rdy`. The next entry appears after the edge.
- Final result: `res_*` is valid 1 cycle after the ALU beat, with `res_vld` high for exactly one cycle per final beat. Back-to-back final beats give back-to-back pulses.
- `alu_rdy` is derived from the registered count only. There is no combinational path from `mux2que_rdy` to `alu_rdy`.
- Sustained throughput: one push and one pop per cycle.

## Test plan
- **Reset values.** Assert `rst` for 2 cycles, then release. Required: `que_dt_vld` = 0, `que_cnt` = 0, `alu_rdy` = 1, `res_vld` = 0, `ovf_err` = 0.
- **Single recirculate.** Push `{0x11, 0x22, cnt = 3}` with `mux2que_rdy` = 0.
  - Next cycle: `que_dt_vld` = 1, `que_a_left` = 0x11, `que_a_right` = 0x22, `que_order_cnt` = 4.
  - Then raise `mux2que_rdy` for 1 cycle. Required: `que_dt_vld` = 0 and `que_cnt` = 0.
- **Fill, overflow and wrap.**
  - Push 8 entries with `a_left` = 0..7 and `mux2que_rdy` = 0. Required: `que_cnt` = 8, `alu_rdy` = 0.
  - Push a 9th entry. Required: it is dropped and `ovf_err` = 1.
  - Pop all 8. Required: `a_left` comes out in order 0..7.
  - Push 3 more and pop them. Required: order is preserved across the pointer wrap.
- **Final beat bypass.** With the queue full, present `alu_order_cnt` = 29 with `a_left` = 0xABCD.
  - Required next cycle: `res_vld` = 1 for exactly one cycle, `res_a_left` = 0xABCD.
  - `que_cnt` stays 8 and `ovf_err` does not change.
- **Simultaneous push and pop.** At `que_cnt` = 3, push and pop in the same cycle for 10 cycles. Required: `que_cnt` stays 3 throughout and FIFO order is intact.
- **Reset mid-traffic.** At `que_cnt` = 5 with `ovf_err` = 1, assert `rst` in a cycle that also has a push and a pop. Required next cycle: `que_cnt` = 0, `que_dt_vld` = 0, `ovf_err` = 0, `res_vld` = 0.
